// File: rtl/xlnx_rst_seq_pkg.sv
// Shared types and defaults for the board-level reset sequencer.
package xlnx_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_HOLD       = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_CORE_DLY   = 3'd3,
    ST_RUN        = 3'd4,
    ST_NDM        = 3'd5
  } rst_state_e;

  localparam int unsigned DefHoldCycles = 63;
  localparam int unsigned DefCoreDelay  = 16;
  localparam int unsigned DefNdmPulse   = 32;

  // Largest of three timer lengths; sizes the shared counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/xlnx_rst_sync.sv
// Two-flop synchroniser for an asynchronous level; clears to 0 on reset.
module xlnx_rst_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw input one stage per clock.
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchroniser register chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= sync_d;
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/xlnx_rst_seq.sv
// Board-level reset sequencer: lock hold-off, DDR calibration gating and
// debug ndmreset re-pulse of the core.
//
//   state          | meaning
//   ---------------+------------------------------------------------
//   WAIT_LOCK  (0) | both resets held, waiting for clock-wizard lock
//   HOLD       (1) | lock seen, waiting HoldCycles of stable lock
//   WAIT_CALIB (2) | peripherals/DDR released, waiting for calibration
//   CORE_DLY   (3) | calibration seen, CoreDelay cycles before core
//   RUN        (4) | everything released, ready
//   NDM        (5) | core held by debug ndmreset (min NdmPulse cycles)
module xlnx_rst_seq
  import xlnx_rst_seq_pkg::*;
#(
  parameter int unsigned HoldCycles = DefHoldCycles,
  parameter int unsigned CoreDelay  = DefCoreDelay,
  parameter int unsigned NdmPulse   = DefNdmPulse
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       locked_i,
  input  logic       calib_done_i,
  input  logic       ndmreset_i,
  output logic       periph_rst_no,
  output logic       core_rst_no,
  output logic       ready_o,
  output logic [2:0] state_o
);

  localparam int unsigned CntMax = max3(HoldCycles, CoreDelay, NdmPulse);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntSat   = CntW'(CntMax);
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] CoreLast = CntW'(CoreDelay - 1);
  localparam logic [CntW-1:0] NdmLast  = CntW'(NdmPulse - 1);

  logic lock_s;
  logic calib_s;

  rst_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            periph_q, periph_d;
  logic            core_q, core_d;
  logic            ready_q, ready_d;

  xlnx_rst_sync u_sync_lock (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (locked_i),
    .q_o    (lock_s)
  );

  xlnx_rst_sync u_sync_calib (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (calib_done_i),
    .q_o    (calib_s)
  );

  // Next state, shared counter and output decode from the next state.
  always_comb begin
    logic [CntW-1:0] cnt_inc;

    state_d  = state_q;
    cnt_inc  = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;

    if (state_q != ST_WAIT_LOCK && !lock_s) begin
      state_d = ST_WAIT_LOCK;
    end else if (!calib_s && (state_q == ST_CORE_DLY || state_q == ST_RUN ||
                              state_q == ST_NDM)) begin
      state_d = ST_WAIT_CALIB;
    end else begin
      case (state_q)
        ST_WAIT_LOCK:  if (lock_s)               state_d = ST_HOLD;
        ST_HOLD:       if (cnt_q == HoldLast)    state_d = ST_WAIT_CALIB;
        ST_WAIT_CALIB: if (calib_s)              state_d = ST_CORE_DLY;
        ST_CORE_DLY:   if (cnt_q == CoreLast)    state_d = ST_RUN;
        ST_RUN:        if (ndmreset_i)           state_d = ST_NDM;
        ST_NDM:        if (cnt_q >= NdmLast && !ndmreset_i) state_d = ST_CORE_DLY;
        default:                                 state_d = ST_WAIT_LOCK;
      endcase
    end

    // Every state entry restarts the timer; otherwise it counts and saturates.
    cnt_d = (state_d != state_q) ? '0 : cnt_inc;

    periph_d = !(state_d == ST_WAIT_LOCK || state_d == ST_HOLD);
    core_d   = (state_d == ST_RUN);
    ready_d  = (state_d == ST_RUN);
  end

  // State, counter and registered reset outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_WAIT_LOCK;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      ready_q  <= ready_d;
    end
  end

  assign periph_rst_no = periph_q;
  assign core_rst_no   = core_q;
  assign ready_o       = ready_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_xlnx_rst_seq.sv
// Scoreboard bench for the reset sequencer. Expected output values are
// queued against absolute clock-edge numbers when stimulus is driven and
// compared on the falling edge after that rising edge.
module tb_xlnx_rst_seq;

  localparam int HOLD = 8;
  localparam int CDLY = 4;
  localparam int NDMP = 6;

  localparam int S_PER = 0;
  localparam int S_CORE = 1;
  localparam int S_RDY = 2;
  localparam int S_ST = 3;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       locked_i = 1'b0;
  logic       calib_done_i = 1'b0;
  logic       ndmreset_i = 1'b0;
  logic       periph_rst_no;
  logic       core_rst_no;
  logic       ready_o;
  logic [2:0] state_o;

  typedef struct {
    int         cyc;
    int         sig;
    logic [2:0] val;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  xlnx_rst_seq #(
    .HoldCycles (HOLD),
    .CoreDelay  (CDLY),
    .NdmPulse   (NDMP)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .locked_i      (locked_i),
    .calib_done_i  (calib_done_i),
    .ndmreset_i    (ndmreset_i),
    .periph_rst_no (periph_rst_no),
    .core_rst_no   (core_rst_no),
    .ready_o       (ready_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d want %0d", tag, edge_n, got, exp);
    end
  endtask

  function automatic logic [2:0] obs(input int sig);
    case (sig)
      S_PER:   return {2'b00, periph_rst_no};
      S_CORE:  return {2'b00, core_rst_no};
      S_RDY:   return {2'b00, ready_o};
      default: return state_o;
    endcase
  endfunction

  function automatic string sig_name(input int sig);
    case (sig)
      S_PER:   return "periph_rst_no";
      S_CORE:  return "core_rst_no";
      S_RDY:   return "ready_o";
      default: return "state_o";
    endcase
  endfunction

  function automatic void expect_at(input int c, input int sig, input logic [2:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = sig;
    e.val = v;
    sb.push_back(e);
  endfunction

  // Compare every entry whose edge has arrived; overdue entries are compared too.
  always @(negedge clk_i) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= edge_n) begin
        chk($sformatf("%s@%0d", sig_name(sb[i].sig), sb[i].cyc), obs(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  // Return 1 ns after rising edge c-1, so anything driven now is sampled at edge c.
  task automatic at_edge(input int c);
    forever begin
      if (edge_n >= c - 1) break;
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    // Async reset state before any clock edge.
    #1;
    chk("rst_periph", {2'b00, periph_rst_no}, 3'd0);
    chk("rst_core", {2'b00, core_rst_no}, 3'd0);
    chk("rst_ready", {2'b00, ready_o}, 3'd0);
    chk("rst_state", state_o, 3'd0);

    at_edge(3);
    rst_ni = 1'b1;
    for (int c = 3; c <= 5; c++) begin
      expect_at(c, S_ST, 3'd0);
      expect_at(c, S_PER, 3'd0);
      expect_at(c, S_CORE, 3'd0);
      expect_at(c, S_RDY, 3'd0);
    end

    // Normal boot: lock at 10 -> HOLD at 12, periph at 20; calib at 40 -> core at 46.
    at_edge(10);
    locked_i = 1'b1;
    expect_at(11, S_ST, 3'd0);
    expect_at(12, S_ST, 3'd1);
    expect_at(19, S_PER, 3'd0);
    expect_at(20, S_PER, 3'd1);
    expect_at(20, S_ST, 3'd2);
    expect_at(20, S_CORE, 3'd0);

    at_edge(40);
    calib_done_i = 1'b1;
    expect_at(41, S_ST, 3'd2);
    expect_at(42, S_ST, 3'd3);
    expect_at(45, S_CORE, 3'd0);
    expect_at(45, S_RDY, 3'd0);
    expect_at(46, S_CORE, 3'd1);
    expect_at(46, S_RDY, 3'd1);
    expect_at(46, S_ST, 3'd4);

    // Lock loss in RUN: both resets assert two edges later.
    at_edge(60);
    locked_i = 1'b0;
    expect_at(61, S_ST, 3'd4);
    expect_at(62, S_ST, 3'd0);
    expect_at(62, S_PER, 3'd0);
    expect_at(62, S_CORE, 3'd0);
    expect_at(62, S_RDY, 3'd0);

    // Relock, then a 3-cycle glitch while in HOLD restarts the hold-off.
    at_edge(70);
    locked_i = 1'b1;
    expect_at(72, S_ST, 3'd1);
    at_edge(75);
    locked_i = 1'b0;
    expect_at(76, S_ST, 3'd1);
    expect_at(77, S_ST, 3'd0);
    at_edge(78);
    locked_i = 1'b1;
    expect_at(79, S_ST, 3'd0);
    expect_at(80, S_ST, 3'd1);
    expect_at(87, S_PER, 3'd0);
    expect_at(88, S_PER, 3'd1);
    expect_at(88, S_ST, 3'd2);
    expect_at(89, S_ST, 3'd3);
    expect_at(92, S_CORE, 3'd0);
    expect_at(93, S_CORE, 3'd1);
    expect_at(93, S_ST, 3'd4);

    // Single-cycle ndmreset: core low for NdmPulse+CoreDelay edges.
    at_edge(100);
    ndmreset_i = 1'b1;
    for (int c = 100; c < 100 + NDMP + CDLY; c++) begin
      expect_at(c, S_CORE, 3'd0);
      expect_at(c, S_PER, 3'd1);
    end
    expect_at(100, S_ST, 3'd5);
    expect_at(100 + NDMP - 1, S_ST, 3'd5);
    expect_at(100 + NDMP, S_ST, 3'd3);
    expect_at(100 + NDMP + CDLY, S_CORE, 3'd1);
    expect_at(100 + NDMP + CDLY, S_RDY, 3'd1);
    expect_at(100 + NDMP + CDLY, S_ST, 3'd4);
    at_edge(101);
    ndmreset_i = 1'b0;

    // ndmreset sampled high on 20 edges: NDM throughout, core back 20+CoreDelay edges on.
    at_edge(120);
    ndmreset_i = 1'b1;
    for (int c = 120; c < 140; c++) expect_at(c, S_ST, 3'd5);
    for (int c = 120; c < 140 + CDLY; c++) expect_at(c, S_CORE, 3'd0);
    expect_at(140, S_ST, 3'd3);
    expect_at(140 + CDLY, S_CORE, 3'd1);
    at_edge(140);
    ndmreset_i = 1'b0;

    // Calibration loss in RUN drops the core only.
    at_edge(160);
    calib_done_i = 1'b0;
    for (int c = 160; c <= 165; c++) expect_at(c, S_PER, 3'd1);
    expect_at(161, S_ST, 3'd4);
    expect_at(162, S_ST, 3'd2);
    expect_at(162, S_CORE, 3'd0);
    expect_at(162, S_RDY, 3'd0);
    at_edge(170);
    calib_done_i = 1'b1;
    expect_at(172, S_ST, 3'd3);

    // Async reset in CORE_DLY, between clock edges.
    at_edge(174);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_periph", {2'b00, periph_rst_no}, 3'd0);
    chk("async_core", {2'b00, core_rst_no}, 3'd0);
    chk("async_ready", {2'b00, ready_o}, 3'd0);
    chk("async_state", state_o, 3'd0);

    // Release: synchronisers re-sample, full sequence replays.
    at_edge(181);
    rst_ni = 1'b1;
    expect_at(181, S_ST, 3'd0);
    expect_at(182, S_ST, 3'd0);
    expect_at(183, S_ST, 3'd1);
    expect_at(190, S_PER, 3'd0);
    expect_at(191, S_PER, 3'd1);
    expect_at(191, S_ST, 3'd2);
    expect_at(192, S_ST, 3'd3);
    expect_at(195, S_CORE, 3'd0);
    expect_at(196, S_CORE, 3'd1);
    expect_at(196, S_RDY, 3'd1);
    expect_at(196, S_ST, 3'd4);

    at_edge(205);
    @(negedge clk_i);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL sb_leftover: %0d expected entries never compared, want 0", sb.size());
      n_err += sb.size();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
